// File: rtl/i2c_slave_pkg.sv
// I2C slave core shared types.
// FSM states, bit counter width and ACK/NACK bus levels.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } state_t;

  localparam int BIT_CNT_W = 3;

  localparam logic ACK_LVL  = 1'b0;
  localparam logic NACK_LVL = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// I2C pin synchronizers and bus event detection.
// Events come from synchronized levels and their delayed copies.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_d;
  logic       sda_d;
  logic       scl_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_raw};
      sda_sync <= {sda_sync[0], sda_raw};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda       = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda;

endmodule

// File: rtl/i2c_slave_core.sv
// I2C register-bank slave: 8 x 8-bit registers behind a
// persistent 3-bit pointer, written and read over the bus.
module i2c_slave_core
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_REGS   = 8
) (
  input  logic       i2c_core_clock_i,
  input  logic       i2c_core_reset_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  input  logic [2:0] host_addr_i,
  output logic [7:0] host_rdata_o,
  output logic       wr_strobe_o,
  output logic [2:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       busy_o
);

  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_sync u_sync (
    .clk       (i2c_core_clock_i),
    .rst       (i2c_core_reset_i),
    .scl_raw   (scl_i),
    .sda_raw   (sda_i),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t               state;
  logic [BIT_CNT_W-1:0] cnt;
  logic [7:0]           shift;
  logic [7:0]           rx_byte;
  logic                 rw;
  logic [2:0]           ptr;
  logic [7:0]           regs [NUM_REGS];

  assign rx_byte      = {shift[6:0], sda};
  assign host_rdata_o = regs[host_addr_i];

  // In ACK states sda_oe_o doubles as the phase flag:
  // first SCL fall asserts it, the second ends the ACK slot.
  always_ff @(posedge i2c_core_clock_i) begin
    if (i2c_core_reset_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      shift       <= '0;
      rw          <= 1'b0;
      ptr         <= '0;
      sda_oe_o    <= 1'b0;
      busy_o      <= 1'b0;
      wr_strobe_o <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe_o <= 1'b0;
      if (start_det) begin
        state    <= ST_ADDR;
        cnt      <= '0;
        sda_oe_o <= 1'b0;
      end else if (stop_det) begin
        state    <= ST_IDLE;
        cnt      <= '0;
        sda_oe_o <= 1'b0;
        busy_o   <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shift <= rx_byte;
            cnt   <= cnt + 1'b1;
            if (cnt == '1) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state  <= ST_ADDR_ACK;
                rw     <= rx_byte[0];
                busy_o <= 1'b1;
              end else begin
                state  <= ST_IDLE;
                busy_o <= 1'b0;
              end
            end
          end
          ST_ADDR_ACK: if (scl_fall) begin
            if (!sda_oe_o) begin
              sda_oe_o <= 1'b1;
            end else begin
              cnt <= '0;
              if (rw) begin
                state    <= ST_RDATA;
                shift    <= regs[ptr];
                sda_oe_o <= ~regs[ptr][7];
              end else begin
                state    <= ST_PTR;
                sda_oe_o <= 1'b0;
              end
            end
          end
          ST_PTR: if (scl_rise) begin
            shift <= rx_byte;
            cnt   <= cnt + 1'b1;
            if (cnt == '1) begin
              ptr   <= rx_byte[2:0];
              state <= ST_PTR_ACK;
            end
          end
          ST_PTR_ACK: if (scl_fall) begin
            if (!sda_oe_o) begin
              sda_oe_o <= 1'b1;
            end else begin
              sda_oe_o <= 1'b0;
              cnt      <= '0;
              state    <= ST_WDATA;
            end
          end
          ST_WDATA: if (scl_rise) begin
            shift <= rx_byte;
            cnt   <= cnt + 1'b1;
            if (cnt == '1) begin
              regs[ptr]   <= rx_byte;
              wr_strobe_o <= 1'b1;
              wr_addr_o   <= ptr;
              wr_data_o   <= rx_byte;
              state       <= ST_WDATA_ACK;
            end
          end
          ST_WDATA_ACK: if (scl_fall) begin
            if (!sda_oe_o) begin
              sda_oe_o <= 1'b1;
            end else begin
              sda_oe_o <= 1'b0;
              ptr      <= ptr + 1'b1;
              cnt      <= '0;
              state    <= ST_WDATA;
            end
          end
          ST_RDATA: if (scl_fall) begin
            cnt   <= cnt + 1'b1;
            shift <= {shift[6:0], 1'b0};
            if (cnt == '1) begin
              state    <= ST_RDATA_ACK;
              sda_oe_o <= 1'b0;
            end else begin
              sda_oe_o <= ~shift[6];
            end
          end
          // cnt==1 marks a master ACK seen on this slot's rise
          ST_RDATA_ACK: begin
            if (scl_rise) begin
              case (sda)
                ACK_LVL: begin
                  ptr <= ptr + 1'b1;
                  cnt <= 3'd1;
                end
                NACK_LVL: state <= ST_IDLE;
                default:  state <= ST_IDLE;
              endcase
            end else if (scl_fall && cnt == 3'd1) begin
              state    <= ST_RDATA;
              cnt      <= '0;
              shift    <= regs[ptr];
              sda_oe_o <= ~regs[ptr][7];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_core.sv
// Directed bench for i2c_slave_core: bit-banged I2C master,
// open-drain SDA model and immediate-assertion checks.
module tb_i2c_slave_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [2:0] host_addr = '0;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int checks = 0;
  int failures = 0;

  int         log_n = 0;
  logic [2:0] log_addr [32];
  logic [7:0] log_data [32];
  int         oe_cnt = 0;
  int         busy_cnt = 0;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_core #(.SLAVE_ADDR(7'h50), .NUM_REGS(8)) dut (
    .i2c_core_clock_i (clk),
    .i2c_core_reset_i (rst),
    .scl_i            (scl),
    .sda_i            (sda_bus),
    .sda_oe_o         (sda_oe),
    .host_addr_i      (host_addr),
    .host_rdata_o     (host_rdata),
    .wr_strobe_o      (wr_strobe),
    .wr_addr_o        (wr_addr),
    .wr_data_o        (wr_data),
    .busy_o           (busy)
  );

  always @(negedge clk) begin
    if (wr_strobe && log_n < 32) begin
      log_addr[log_n] = wr_addr;
      log_data[log_n] = wr_data;
      log_n = log_n + 1;
    end
    if (sda_oe) oe_cnt = oe_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(5);
    scl = 1'b1;   tick(5);
    sda_m = 1'b0; tick(5);
    scl = 1'b0;   tick(5);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(5);
    scl = 1'b1;   tick(5);
    sda_m = 1'b1; tick(10);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; tick(5);
    scl = 1'b1; tick(10);
    scl = 1'b0; tick(5);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; tick(5);
    scl = 1'b1;   tick(5);
    ack = sda_bus; tick(5);
    scl = 1'b0;   tick(5);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(5);
      scl = 1'b1; tick(5);
      b[i] = sda_bus; tick(5);
      scl = 1'b0;
    end
    tick(5);
    sda_m = mack; tick(5);
    scl = 1'b1;   tick(10);
    scl = 1'b0;   tick(5);
    sda_m = 1'b1;
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] idx,
                         input logic [7:0] exp);
    host_addr = idx;
    #1;
    chk(tag, host_rdata, exp);
  endtask

  logic       ack;
  logic [7:0] rd;
  int         base;
  int         oe_base;
  int         busy_base;

  initial begin
    tick(4);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_strobe", wr_strobe, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    rst = 1'b0;
    tick(4);
    for (int i = 0; i < 8; i++) chk_reg("rst_reg", 3'(i), 8'h00);

    // write 0x11,0x22 starting at register 3
    base = log_n;
    i2c_start();
    send_byte(8'hA0, ack); chk("w1_ack_addr", ack, 0);
    send_byte(8'h03, ack); chk("w1_ack_ptr", ack, 0);
    send_byte(8'h11, ack); chk("w1_ack_d0", ack, 0);
    send_byte(8'h22, ack); chk("w1_ack_d1", ack, 0);
    chk("w1_busy", busy, 1);
    i2c_stop();
    chk("w1_busy_after_stop", busy, 0);
    chk_reg("w1_reg3", 3'd3, 8'h11);
    chk_reg("w1_reg4", 3'd4, 8'h22);
    chk("w1_strobes", log_n - base, 2);
    chk("w1_strb0_addr", log_addr[base], 3);
    chk("w1_strb0_data", log_data[base], 8'h11);
    chk("w1_strb1_addr", log_addr[base+1], 4);
    chk("w1_strb1_data", log_data[base+1], 8'h22);

    // pointer wrap 7 -> 0
    i2c_start();
    send_byte(8'hA0, ack); chk("w2_ack_addr", ack, 0);
    send_byte(8'h07, ack); chk("w2_ack_ptr", ack, 0);
    send_byte(8'hAA, ack); chk("w2_ack_d0", ack, 0);
    send_byte(8'hBB, ack); chk("w2_ack_d1", ack, 0);
    i2c_stop();
    chk_reg("w2_reg7", 3'd7, 8'hAA);
    chk_reg("w2_reg0", 3'd0, 8'hBB);

    // set pointer, repeated START, read two bytes
    i2c_start();
    send_byte(8'hA0, ack); chk("r1_ack_addr", ack, 0);
    send_byte(8'h03, ack); chk("r1_ack_ptr", ack, 0);
    i2c_start();
    send_byte(8'hA1, ack); chk("r1_ack_raddr", ack, 0);
    read_byte(1'b0, rd);   chk("r1_byte0", rd, 8'h11);
    read_byte(1'b1, rd);   chk("r1_byte1", rd, 8'h22);
    tick(3);
    chk("r1_released", sda_oe, 0);
    chk("r1_sda_high", sda_bus, 1);
    i2c_stop();

    // read without pointer write continues from ptr=4
    i2c_start();
    send_byte(8'hA1, ack); chk("r2_ack_addr", ack, 0);
    read_byte(1'b1, rd);   chk("r2_byte0", rd, 8'h22);
    i2c_stop();

    // foreign address 0xA2 must be ignored
    oe_base = oe_cnt;
    busy_base = busy_cnt;
    base = log_n;
    i2c_start();
    send_byte(8'hA2, ack); chk("miss_nack", ack, 1);
    i2c_stop();
    chk("miss_no_drive", oe_cnt - oe_base, 0);
    chk("miss_no_busy", busy_cnt - busy_base, 0);
    chk("miss_no_strobe", log_n - base, 0);

    // reset during data bit 4 of a write byte
    i2c_start();
    send_byte(8'hA0, ack); chk("rst_tx_ack_addr", ack, 0);
    send_byte(8'h05, ack); chk("rst_tx_ack_ptr", ack, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    sda_m = 1'b1; tick(2);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_sda_oe", sda_oe, 0);
    chk("rst_mid_busy", busy, 0);
    tick(1);
    rst = 1'b0;
    tick(2);
    for (int i = 0; i < 8; i++) chk_reg("rst_mid_reg", 3'(i), 8'h00);
    i2c_stop();

    // transaction after reset decodes normally
    base = log_n;
    i2c_start();
    send_byte(8'hA0, ack); chk("post_ack_addr", ack, 0);
    send_byte(8'h02, ack); chk("post_ack_ptr", ack, 0);
    send_byte(8'h77, ack); chk("post_ack_d0", ack, 0);
    i2c_stop();
    chk_reg("post_reg2", 3'd2, 8'h77);
    chk("post_strobes", log_n - base, 1);
    chk("post_strb_addr", log_addr[base], 2);
    chk("post_strb_data", log_data[base], 8'h77);

    // STOP mid-byte discards the partial byte
    base = log_n;
    i2c_start();
    send_byte(8'hA0, ack); chk("part_ack_addr", ack, 0);
    send_byte(8'h01, ack); chk("part_ack_ptr", ack, 0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    i2c_stop();
    chk("part_no_strobe", log_n - base, 0);
    chk_reg("part_reg1", 3'd1, 8'h00);
    chk("part_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
